// File: rtl/eth_rx_if.sv
// RMII receive bundle: dibit/carrier input side plus the byte stream and frame status output side.
interface eth_rx_if;
  logic [1:0]  Rxd;
  logic        Crs_Dv;
  logic [9:0]  Eth_Byte;
  logic        Eth_Byte_Valid;
  logic        Frame_Done;
  logic        Crc_Ok;
  logic        Len_Err;
  logic        Align_Err;
  logic [10:0] Frame_Len;

  modport slave (
    input  Rxd, Crs_Dv,
    output Eth_Byte, Eth_Byte_Valid, Frame_Done, Crc_Ok, Len_Err, Align_Err, Frame_Len
  );
  modport master (
    output Rxd, Crs_Dv,
    input  Eth_Byte, Eth_Byte_Valid, Frame_Done, Crc_Ok, Len_Err, Align_Err, Frame_Len
  );
endinterface

// File: rtl/eth_rx.sv
// RMII receiver: preamble/SFD lock, dibit-to-byte assembly, CRC-32 residue check and
// per-frame length/alignment status, emitting bytes with SOP/EOP via a one-byte holding register.
module eth_rx #(
  parameter int pMIN_FRAME = 64,
  parameter int pMAX_FRAME = 1518
) (
  input  logic     Clk,
  input  logic     Rst,
  eth_rx_if.slave  rx
);
  localparam logic [1:0]  S_DROP = 2'd0;
  localparam logic [1:0]  S_IDLE = 2'd1;
  localparam logic [1:0]  S_PRE  = 2'd2;
  localparam logic [1:0]  S_DATA = 2'd3;
  localparam int          CW      = 16;
  localparam logic [CW-1:0] MIN_C = CW'(pMIN_FRAME);
  localparam logic [CW-1:0] MAX_C = CW'(pMAX_FRAME);
  localparam logic [31:0] CRC_RES = 32'hDEBB20E3;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [10:0] sat_len(input logic [CW-1:0] n);
    return (n > CW'(2047)) ? 11'h7FF : n[10:0];
  endfunction

  logic [1:0]    rxd_q;
  logic          crs_q;
  logic [1:0]    state_q, state_d;
  logic [7:0]    sr_q, sr_d;
  logic [1:0]    dib_q, dib_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   crc_q, crc_d;
  logic [7:0]    held_q, held_d;
  logic [9:0]    byte_q, byte_d;
  logic          bvld_q, bvld_d;
  logic          done_q, done_d;
  logic          crc_ok_q, crc_ok_d;
  logic          len_err_q, len_err_d;
  logic          align_q, align_d;
  logic [10:0]   flen_q, flen_d;
  logic [7:0]    new_byte;

  // Input stage is not reset so a carrier that stays high across Rst keeps the FSM in DROP.
  always_ff @(posedge Clk) begin
    rxd_q <= rx.Rxd;
    crs_q <= rx.Crs_Dv;
  end

  assign new_byte = {rxd_q, sr_q[7:2]};

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    dib_d     = dib_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    held_d    = held_q;
    byte_d    = byte_q;
    bvld_d    = 1'b0;
    done_d    = 1'b0;
    crc_ok_d  = crc_ok_q;
    len_err_d = len_err_q;
    align_d   = align_q;
    flen_d    = flen_q;
    case (state_q)
      S_DROP: if (!crs_q) state_d = S_IDLE;
      S_IDLE: begin
        if (crs_q) begin
          if (rxd_q == 2'b01)      state_d = S_PRE;
          else if (rxd_q != 2'b00) state_d = S_DROP;
        end
      end
      S_PRE: begin
        if (!crs_q) state_d = S_IDLE;
        else if (rxd_q == 2'b11) begin
          state_d = S_DATA;
          sr_d    = '0;
          dib_d   = '0;
          cnt_d   = '0;
          crc_d   = 32'hFFFFFFFF;
        end else if (rxd_q != 2'b01) state_d = S_DROP;
      end
      default: begin
        if (!crs_q) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          if (cnt_q != '0) begin
            bvld_d = 1'b1;
            byte_d = {cnt_q == CW'(1), 1'b1, held_q};
          end
          crc_ok_d  = (crc_q == CRC_RES) && (dib_q == 2'd0);
          len_err_d = (cnt_q < MIN_C) || (cnt_q > MAX_C);
          align_d   = (dib_q != 2'd0);
          flen_d    = sat_len(cnt_q);
        end else begin
          sr_d  = new_byte;
          dib_d = dib_q + 2'd1;
          if (dib_q == 2'd3) begin
            if (cnt_q == MAX_C) begin
              // Oversize: close the frame on the held byte and ignore the rest of the carrier.
              state_d   = S_DROP;
              bvld_d    = 1'b1;
              byte_d    = {cnt_q == CW'(1), 1'b1, held_q};
              done_d    = 1'b1;
              crc_ok_d  = 1'b0;
              len_err_d = 1'b1;
              align_d   = 1'b0;
              flen_d    = sat_len(cnt_q);
            end else begin
              if (cnt_q != '0) begin
                bvld_d = 1'b1;
                byte_d = {cnt_q == CW'(1), 1'b0, held_q};
              end
              held_d = new_byte;
              crc_d  = crc_upd(crc_q, new_byte);
              cnt_d  = cnt_q + CW'(1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_DROP;
      sr_q      <= '0;
      dib_q     <= '0;
      cnt_q     <= '0;
      crc_q     <= 32'hFFFFFFFF;
      held_q    <= '0;
      byte_q    <= '0;
      bvld_q    <= 1'b0;
      done_q    <= 1'b0;
      crc_ok_q  <= 1'b0;
      len_err_q <= 1'b0;
      align_q   <= 1'b0;
      flen_q    <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      dib_q     <= dib_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      held_q    <= held_d;
      byte_q    <= byte_d;
      bvld_q    <= bvld_d;
      done_q    <= done_d;
      crc_ok_q  <= crc_ok_d;
      len_err_q <= len_err_d;
      align_q   <= align_d;
      flen_q    <= flen_d;
    end
  end

  assign rx.Eth_Byte       = byte_q;
  assign rx.Eth_Byte_Valid = bvld_q;
  assign rx.Frame_Done     = done_q;
  assign rx.Crc_Ok         = crc_ok_q;
  assign rx.Len_Err        = len_err_q;
  assign rx.Align_Err      = align_q;
  assign rx.Frame_Len      = flen_q;
endmodule

// File: tb/tb_eth_rx.sv
// Scoreboard bench for eth_rx: frames are built with their own FCS, expected bytes/status
// are queued as each frame is sent, and a negedge monitor pops and compares DUT output.
module tb_eth_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  eth_rx_if bus();
  eth_rx #(.pMIN_FRAME(64), .pMAX_FRAME(1518)) dut (.Clk(clk), .Rst(rst), .rx(bus));

  typedef struct packed {
    logic        ok;
    logic        le;
    logic        al;
    logic [10:0] len;
  } stat_t;

  logic [9:0] exp_b[$];
  stat_t      exp_s[$];
  logic [7:0] fb[$];
  logic [9:0] eb;
  stat_t      es;
  stat_t      gs;
  int total = 0;
  int bad   = 0;
  bit sb_on = 1'b0;

  always @(negedge clk) begin
    if (sb_on) begin
      if (bus.Eth_Byte_Valid) begin
        total++;
        if (exp_b.size() == 0) begin
          bad++;
          $display("FAIL unexpected_byte got=%h want=none", bus.Eth_Byte);
        end else begin
          eb = exp_b.pop_front();
          if (bus.Eth_Byte !== eb) begin
            bad++;
            $display("FAIL byte got=%h want=%h", bus.Eth_Byte, eb);
          end
        end
      end
      if (bus.Frame_Done) begin
        total++;
        gs = '{bus.Crc_Ok, bus.Len_Err, bus.Align_Err, bus.Frame_Len};
        if (exp_s.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done got=%h want=none", gs);
        end else begin
          es = exp_s.pop_front();
          if (gs !== es) begin
            bad++;
            $display("FAIL status got crc=%b len_err=%b align=%b len=%0d want crc=%b len_err=%b align=%b len=%0d",
                     gs.ok, gs.le, gs.al, gs.len, es.ok, es.le, es.al, es.len);
          end
          total++;
          if (es.len != 0 && !(bus.Eth_Byte_Valid === 1'b1 && bus.Eth_Byte[8] === 1'b1)) begin
            bad++;
            $display("FAIL done_eop got vld=%b eop=%b want 1 1", bus.Eth_Byte_Valid, bus.Eth_Byte[8]);
          end
        end
      end
    end
  end

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic dibit(input logic [1:0] d, input logic dv);
    @(negedge clk);
    bus.Rxd    = d;
    bus.Crs_Dv = dv;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) dibit(b[2*k +: 2], 1'b1);
  endtask

  task automatic preamble();
    for (int k = 0; k < 7; k++) send_byte(8'h55);
    send_byte(8'hD5);
  endtask

  // n = bytes before FCS; flip corrupts payload byte 20 after the FCS is computed
  task automatic make_frame(input int n, input bit flip);
    logic [31:0] c;
    fb.delete();
    for (int k = 0; k < 6; k++) fb.push_back(8'hFF);
    fb.push_back(8'h02);
    for (int k = 0; k < 4; k++) fb.push_back(8'h00);
    fb.push_back(8'h01);
    fb.push_back(8'hFF);
    fb.push_back(8'hFF);
    while (fb.size() < n) fb.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (fb[k]) c = crc_byte(c, fb[k]);
    c = ~c;
    if (flip) fb[20] = fb[20] ^ 8'h01;
    for (int k = 0; k < 4; k++) fb.push_back(c[8*k +: 8]);
  endtask

  task automatic send_frame(input int extra, input int gap);
    preamble();
    foreach (fb[k]) send_byte(fb[k]);
    for (int k = 0; k < extra; k++) dibit(2'b10, 1'b1);
    for (int k = 0; k < gap; k++) dibit(2'b00, 1'b0);
  endtask

  task automatic push_exp(input int nmax, input bit ok, input bit le, input bit al, input int len);
    int n;
    n = (fb.size() < nmax) ? fb.size() : nmax;
    for (int k = 0; k < n; k++) exp_b.push_back({k == 0, k == n - 1, fb[k]});
    exp_s.push_back('{ok, le, al, 11'(len)});
  endtask

  task automatic settle();
    repeat (24) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.Rxd = 2'b00;
    bus.Crs_Dv = 1'b0;
    repeat (3) @(negedge clk);
    total += 7;
    if (bus.Eth_Byte_Valid !== 1'b0) begin bad++; $display("FAIL rst_vld got=%b want=0", bus.Eth_Byte_Valid); end
    if (bus.Frame_Done !== 1'b0)     begin bad++; $display("FAIL rst_done got=%b want=0", bus.Frame_Done); end
    if (bus.Eth_Byte !== 10'd0)      begin bad++; $display("FAIL rst_byte got=%h want=0", bus.Eth_Byte); end
    if (bus.Crc_Ok !== 1'b0)         begin bad++; $display("FAIL rst_crc got=%b want=0", bus.Crc_Ok); end
    if (bus.Len_Err !== 1'b0)        begin bad++; $display("FAIL rst_len_err got=%b want=0", bus.Len_Err); end
    if (bus.Align_Err !== 1'b0)      begin bad++; $display("FAIL rst_align got=%b want=0", bus.Align_Err); end
    if (bus.Frame_Len !== 11'd0)     begin bad++; $display("FAIL rst_len got=%0d want=0", bus.Frame_Len); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    sb_on = 1'b1;
  endtask

  task automatic test_valid();
    make_frame(60, 1'b0);
    push_exp(64, 1'b1, 1'b0, 1'b0, 64);
    send_frame(0, 2);
    settle();
    total++;
    if (exp_b.size() + exp_s.size() != 0) begin bad++; $display("FAIL valid_pending got=%0d want=0", exp_b.size() + exp_s.size()); end
  endtask

  task automatic test_bad_crc();
    make_frame(60, 1'b1);
    push_exp(64, 1'b0, 1'b0, 1'b0, 64);
    send_frame(0, 2);
    settle();
    total++;
    if (exp_b.size() + exp_s.size() != 0) begin bad++; $display("FAIL badcrc_pending got=%0d want=0", exp_b.size() + exp_s.size()); end
  endtask

  task automatic test_short();
    make_frame(46, 1'b0);
    push_exp(50, 1'b1, 1'b1, 1'b0, 50);
    send_frame(0, 2);
    settle();
    total++;
    if (exp_b.size() + exp_s.size() != 0) begin bad++; $display("FAIL short_pending got=%0d want=0", exp_b.size() + exp_s.size()); end
  endtask

  task automatic test_long();
    make_frame(1596, 1'b0);
    push_exp(1518, 1'b0, 1'b1, 1'b0, 1518);
    send_frame(0, 2);
    settle();
    total++;
    if (exp_b.size() + exp_s.size() != 0) begin bad++; $display("FAIL long_pending got=%0d want=0", exp_b.size() + exp_s.size()); end
  endtask

  task automatic test_align();
    make_frame(60, 1'b0);
    push_exp(64, 1'b0, 1'b0, 1'b1, 64);
    send_frame(1, 2);
    settle();
    total++;
    if (exp_b.size() + exp_s.size() != 0) begin bad++; $display("FAIL align_pending got=%0d want=0", exp_b.size() + exp_s.size()); end
  endtask

  task automatic test_no_byte();
    preamble();
    exp_s.push_back('{1'b0, 1'b1, 1'b0, 11'd0});
    dibit(2'b00, 1'b0);
    dibit(2'b00, 1'b0);
    settle();
    total++;
    if (exp_b.size() + exp_s.size() != 0) begin bad++; $display("FAIL nobyte_pending got=%0d want=0", exp_b.size() + exp_s.size()); end
  endtask

  task automatic test_bad_preamble();
    make_frame(60, 1'b0);
    send_byte(8'h55);
    send_byte(8'h55);
    dibit(2'b10, 1'b1);
    foreach (fb[k]) send_byte(fb[k]);
    dibit(2'b00, 1'b0);
    push_exp(64, 1'b1, 1'b0, 1'b0, 64);
    send_frame(0, 2);
    settle();
    total++;
    if (exp_b.size() + exp_s.size() != 0) begin bad++; $display("FAIL badpre_pending got=%0d want=0", exp_b.size() + exp_s.size()); end
  endtask

  task automatic test_back_to_back();
    make_frame(60, 1'b0);
    push_exp(64, 1'b1, 1'b0, 1'b0, 64);
    send_frame(0, 1);
    make_frame(70, 1'b0);
    push_exp(74, 1'b1, 1'b0, 1'b0, 74);
    send_frame(0, 1);
    dibit(2'b00, 1'b0);
    settle();
    total++;
    if (exp_b.size() + exp_s.size() != 0) begin bad++; $display("FAIL b2b_pending got=%0d want=0", exp_b.size() + exp_s.size()); end
  endtask

  task automatic test_rst_mid();
    sb_on = 1'b0;
    make_frame(60, 1'b0);
    preamble();
    for (int k = 0; k < 29; k++) send_byte(fb[k]);
    @(negedge clk);
    bus.Rxd = fb[29][1:0];
    bus.Crs_Dv = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.Rxd = fb[29][3:2];
    total += 4;
    if (bus.Eth_Byte_Valid !== 1'b0) begin bad++; $display("FAIL midrst_vld got=%b want=0", bus.Eth_Byte_Valid); end
    if (bus.Eth_Byte !== 10'd0)      begin bad++; $display("FAIL midrst_byte got=%h want=0", bus.Eth_Byte); end
    if (bus.Crc_Ok !== 1'b0)         begin bad++; $display("FAIL midrst_crc got=%b want=0", bus.Crc_Ok); end
    if (bus.Frame_Len !== 11'd0)     begin bad++; $display("FAIL midrst_len got=%0d want=0", bus.Frame_Len); end
    exp_b.delete();
    exp_s.delete();
    sb_on = 1'b1;
    dibit(fb[29][5:4], 1'b1);
    dibit(fb[29][7:6], 1'b1);
    for (int k = 30; k < fb.size(); k++) send_byte(fb[k]);
    dibit(2'b00, 1'b0);
    make_frame(60, 1'b0);
    push_exp(64, 1'b1, 1'b0, 1'b0, 64);
    send_frame(0, 2);
    settle();
    total++;
    if (exp_b.size() + exp_s.size() != 0) begin bad++; $display("FAIL midrst_pending got=%0d want=0", exp_b.size() + exp_s.size()); end
  endtask

  initial begin
    test_reset();
    test_valid();
    test_bad_crc();
    test_short();
    test_long();
    test_align();
    test_no_byte();
    test_bad_preamble();
    test_back_to_back();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/eth_rx.md
Name: eth_rx

Overview:
- RMII receive path: samples Rxd/Crs_Dv, detects preamble/SFD, assembles LSB-first dibits into bytes, and checks the CRC-32 FCS.
- Emits every post-SFD byte (dest addr through FCS) in the same 10-bit SOP/EOP byte format that eth_tx consumes.
- Reports per-frame status so a downstream FIFO/MAC filter can commit or discard the frame.

Parameters:
pMIN_FRAME, 64, minimum legal frame length in bytes (dest addr through FCS inclusive)
pMAX_FRAME, 1518, maximum legal frame length in bytes; exceeding truncates the frame

Ports:
Clk  in  1  50 MHz RMII reference clock; one dibit per cycle
Rst  in  1  synchronous, active-high reset
Rxd  in  2  RMII receive dibit, LSB-first within each byte
Crs_Dv  in  1  RMII carrier-sense/data-valid
Eth_Byte  out  10  [9]=SOP, [8]=EOP, [7:0]=data byte
Eth_Byte_Valid  out  1  Eth_Byte qualifier, one-cycle pulse per byte
Frame_Done  out  1  one-cycle pulse, coincident with the EOP byte
Crc_Ok  out  1  valid with Frame_Done; 1 = FCS residue correct
Len_Err  out  1  valid with Frame_Done; 1 = length < pMIN_FRAME or > pMAX_FRAME
Align_Err  out  1  valid with Frame_Done; 1 = post-SFD dibit count not a multiple of 4
Frame_Len  out  11  valid with Frame_Done; byte count including FCS, saturates at 2047

Behaviour:
- Input stage: Rxd and Crs_Dv are registered once (Rxd_r, Crs_Dv_r). All decode below uses the registered values.
- Reset:
  - All outputs 0; FSM goes to DROP; counters and held byte cleared.
  - Any in-progress frame is discarded with no EOP.
- FSM states: DROP, IDLE, PREAMBLE, DATA.
  - DROP: wait for Crs_Dv_r=0, then go to IDLE. This prevents mid-frame lock after reset or after an error.
  - IDLE: on Crs_Dv_r=1 and Rxd_r=2'b01, go to PREAMBLE. On Crs_Dv_r=1 and Rxd_r=2'b00, stay in IDLE. On any other Rxd_r with Crs_Dv_r=1, go to DROP.
  - PREAMBLE: Rxd_r=01 stays; Rxd_r=11 (SFD last dibit) goes to DATA and clears the byte shifter, dibit count, byte count and CRC. Rxd_r=00/10, or Crs_Dv_r=0, goes to DROP (IDLE if Crs_Dv_r=0). No byte is output.
  - DATA:
    - Each cycle with Crs_Dv_r=1, shift byte_sr <= {Rxd_r, byte_sr[7:2]} and increment the 2-bit dibit count.
    - When the count wraps to 0, the byte is complete: update the CRC and increment the byte count.
- Output holding (one-byte lookahead, needed to mark EOP):
  - A completed byte is held in a register.
  - When the next byte completes, the held byte is emitted (Eth_Byte_Valid=1, EOP=0) and replaced by the new byte.
  - The first emitted byte of a frame carries SOP=1.
- End of frame (DATA and Crs_Dv_r=0):
  - Next cycle: the held byte is emitted with EOP=1 (SOP=1 also if it is the only byte). Frame_Done=1 and the status outputs are driven in the same cycle.
  - Align_Err=1 if the dibit count is nonzero; the partial byte is dropped.
  - FSM goes to IDLE.
  - If no byte has completed (SFD followed immediately by carrier loss): no byte output, and Frame_Done pulses with Len_Err=1 and Frame_Len=0.
- CRC:
  - Reflected CRC-32, poly 0xEDB88320, init 0xFFFFFFFF, byte-wise over all post-SFD bytes including the FCS.
  - Crc_Ok=1 if and only if the register equals 0xDEBB20E3 after the last byte.
  - Crc_Ok is forced 0 when Align_Err=1.
- Length:
  - Len_Err=1 if Frame_Len < pMIN_FRAME.
  - If the byte count would exceed pMAX_FRAME: emit the held byte with EOP=1 and Frame_Done=1, set Len_Err=1 and Crc_Ok=0, and go to DROP. No further bytes are output for that carrier event.
- Status outputs hold their values until the next Frame_Done; Frame_Done and Eth_Byte_Valid are single-cycle.
- Back-to-back frames: a single cycle of Crs_Dv_r=0 is sufficient to end the frame and re-arm IDLE.
- Latency: an interior byte's last dibit on Rxd appears at Eth_Byte 6 cycles later (input register, shift, completion, hold, plus the 4-cycle wait for the next byte).
- Throughput: at most one byte per 4 cycles.

Test Plan:
- Valid frame: 7x0x55 + 0xD5 preamble/SFD, 60-byte payload from eth_tx (dest FF..FF, src 02:00:00:00:00:01, len/type FFFF, zero pad) plus correct FCS -> 64 bytes out; SOP on 0xFF, EOP on the last FCS byte; Frame_Done with Crc_Ok=1, Len_Err=0, Align_Err=0, Frame_Len=64.
- Same frame with bit 0 of payload byte 20 flipped -> identical byte stream, Crc_Ok=0, Frame_Len=64.
- 50-byte frame with valid FCS -> Crc_Ok=1, Len_Err=1, Frame_Len=50. 1600-byte frame -> EOP after byte 1518, Len_Err=1, Crc_Ok=0, no bytes 1519+.
- Valid 64-byte frame plus one extra dibit before Crs_Dv falls -> 64 bytes out, Align_Err=1, Crc_Ok=0.
- Preamble corrupted with Rxd=10 mid-preamble -> no Eth_Byte_Valid, no Frame_Done. Next valid frame after a 1-cycle Crs_Dv gap is received correctly.
- Rst asserted for 1 cycle at byte 30 while Crs_Dv stays high -> outputs 0, no EOP, no bytes until Crs_Dv drops. The following frame is received with Crc_Ok=1.
